// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and helpers for the pipe_stage_reg pipeline stage.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package pipe_stage_reg_pkg;

  // Stage occupancy states; the encoding equals the number of held beats.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int unsigned OCC_W = 2;

  // Total bus width for a given lane count and lane width.
  function automatic int unsigned bus_width(input int unsigned lanes,
                                            input int unsigned bit_number);
    return lanes * bit_number;
  endfunction

  // Lowest bit index of a lane within the packed payload bus.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned bit_number);
    return lane * bit_number;
  endfunction

  // Beats held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input stage_state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_BUSY:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_register.sv
// Generic storage register with hold (freeze) control and async clear.
// Latency: 1 cycle from in to out when freeze=0.
// Backpressure: none; freeze=1 simply holds the stored value.
module pipe_stage_reg_register #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         rst,
  input  logic         clk,
  input  logic         freeze,
  output logic [W-1:0] out
);

  // Capture the input unless frozen; clear to zero on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (!freeze) begin
      out <= in;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register, optional skid entry (PIPE_STAGE_SKID_EN) for a registered in_ready.
// Latency: 1 cycle in_data -> out_data; holds up to 2 beats with skid, 1 without.
// Backpressure: freeze stalls both sides; flush kills held beats; in_ready drops when full.
import pipe_stage_reg_pkg::*;

module pipe_stage_reg #(
  parameter int BIT_NUMBER = 32,
  parameter int LANES      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          freeze,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*BIT_NUMBER-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*BIT_NUMBER-1:0]   out_data,
  output logic [1:0]                    occupancy
);

  localparam int DATA_W = int'(bus_width(LANES, BIT_NUMBER));

  stage_state_e      state_q;
  stage_state_e      state_d;
  logic              in_fire;
  logic              out_fire;
  logic              main_ld;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = occ_of(state_q);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && !freeze;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_ld;
  logic              main_from_skid;
  logic [DATA_W-1:0] skid_q;
  logic              rdy_q;

  // Acceptance is decided from next state so in_ready leaves a flop, gated only by freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= (state_d != ST_FULL);
    end
  end

  assign in_ready = rdy_q && !freeze;
  assign main_d   = main_from_skid ? skid_q : in_data;

  pipe_stage_reg_register #(.W(DATA_W)) u_skid (
    .in     (in_data),
    .rst    (rst),
    .clk    (clk),
    .freeze (!skid_ld),
    .out    (skid_q)
  );
`else
  // Without a skid entry, a beat may enter only when the held one leaves this cycle.
  assign in_ready = (!out_valid || out_ready) && !freeze;
  assign main_d   = in_data;
`endif

  pipe_stage_reg_register #(.W(DATA_W)) u_main (
    .in     (main_d),
    .rst    (rst),
    .clk    (clk),
    .freeze (!main_ld),
    .out    (main_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and storage load enables; flush wins, freeze already masks both fires.
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_ld = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
`endif
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_BUSY;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, corner sequences, random vs queue model.
// Latency: n/a (testbench).
// Backpressure: n/a; honours PIPE_STAGE_SKID_EN to pick expectations.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int BN = 32;
  localparam int LN = 2;
  localparam int DW = BN * LN;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          freeze;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.BIT_NUMBER(BN), .LANES(LN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic fl, input logic fz, input logic iv,
                       input logic ordy, input logic [DW-1:0] d);
    flush = fl; freeze = fz; in_valid = iv; out_ready = ordy; in_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: apply inputs at negedge, then observe before the next rising edge.
  task automatic cyc(input logic fl, input logic fz, input logic iv,
                     input logic ordy, input logic [DW-1:0] d);
    @(negedge clk);
    drive(fl, fz, iv, ordy, d);
    #1;
  endtask

  typedef struct {
    logic          fl, fz, iv, ordy;
    logic [DW-1:0] d;
    logic          ov, ir;
    logic [1:0]    occ;
    logic [DW-1:0] od;
  } vec_t;

  vec_t          tbl[13];
  logic [DW-1:0] beat_a;
  logic [DW-1:0] q[$];
  logic          exp_ir;
  logic [DW-1:0] exp_od;
  logic          r_fl, r_fz, r_iv, r_or;
  logic [DW-1:0] r_d;

  initial begin
    beat_a = '0;
    beat_a[lane_lsb(0, BN) +: BN] = 32'hE3A0_1001;
    beat_a[lane_lsb(1, BN) +: BN] = 32'h0000_0004;

    //            fl    fz    iv    or    data       ov    ir    occ   od
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b1, 2'd0, 64'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, beat_a, 1'b0, 1'b1, 2'd0, 64'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'd0,  1'b1, 1'b1, 2'd1, beat_a};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b1, 2'd0, beat_a};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'd5,  1'b0, 1'b1, 2'd0, beat_a};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'd6,  1'b1, 1'b0, 2'd1, 64'd5};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'd6,  1'b1, 1'b0, 2'd1, 64'd5};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'd6,  1'b1, 1'b0, 2'd1, 64'd5};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'd0,  1'b1, 1'b1, 2'd1, 64'd5};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'd7,  1'b0, 1'b1, 2'd0, 64'd5};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'd8,  1'b1, 1'b1, 2'd1, 64'd7};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'd9,  1'b1, 1'b0, 2'd1, 64'd8};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b1, 2'd0, 64'd8};

    // Vector table: reset state, first transfer, hold, freeze, back-to-back, flush.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].fl, tbl[i].fz, tbl[i].iv, tbl[i].ordy, tbl[i].d);
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d in_ready", i),  64'(in_ready),  64'(tbl[i].ir));
      chk($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(tbl[i].occ));
      chk($sformatf("vec%0d out_data", i),  out_data,       tbl[i].od);
    end

`ifdef PIPE_STAGE_SKID_EN
    // Two beats under backpressure fill the skid, then drain in order.
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd2);
    chk("skid busy in_ready", 64'(in_ready), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("skid full occupancy", 64'(occupancy), 64'd2);
    chk("skid full in_ready",  64'(in_ready),  64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
    chk("skid drain first", out_data, 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
    chk("skid drain second", out_data, 64'd2);
    chk("skid drain second valid", 64'(out_valid), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
    chk("skid drained valid", 64'(out_valid), 64'd0);

    // Flush from FULL beats freeze and an offered beat.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 64'd5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("flush full out_valid", 64'(out_valid), 64'd0);
    chk("flush full occupancy", 64'(occupancy), 64'd0);
    chk("flush full in_ready",  64'(in_ready),  64'd1);
`endif

    // Asynchronous reset while holding the maximum number of beats.
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h11);
    if (SKID) cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h22);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("pre-reset occupancy", 64'(occupancy), SKID ? 64'd2 : 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst out_data",  out_data,       64'd0);
    chk("async rst occupancy", 64'(occupancy), 64'd0);
    chk("async rst in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h33);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("post-reset first beat", out_data, 64'h33);
    chk("post-reset occupancy", 64'(occupancy), 64'd1);

    // Random traffic against an order-preserving queue model.
    do_reset();
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      r_fl = ($urandom_range(0, 63) == 0);
      r_fz = ($urandom_range(0, 7) == 0);
      r_iv = ($urandom_range(0, 2) != 0);
      r_or = ($urandom_range(0, 2) != 0);
      r_d  = {$urandom, $urandom};
      cyc(r_fl, r_fz, r_iv, r_or, r_d);
      exp_ir = SKID ? (q.size() < 2 && !r_fz) : ((q.size() == 0 || r_or) && !r_fz);
      exp_od = (q.size() != 0) ? q[0] : '0;
      chk("rand out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("rand in_ready",  64'(in_ready),  64'(exp_ir));
      chk("rand occupancy", 64'(occupancy), 64'(q.size()));
      if (q.size() != 0) chk("rand out_data", out_data, exp_od);
      if (r_fl) begin
        q.delete();
      end else begin
        if (q.size() != 0 && r_or && !r_fz) void'(q.pop_front());
        if (r_iv && exp_ir) q.push_back(r_d);
      end
      if (total - passed > 100) break;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
